// File: rtl/rt_display_pkg.sv
// Shared types and segment encodings for the counter read/display path.
package rt_display_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {SCAN, BLANK} scan_state_t;

  // Active-high {g,f,e,d,c,b,a}; codes 10-15 render as blank
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/rt_count_display_scan_if.sv
// Counter-side snapshot handshake plus the board display pins.
interface rt_count_display_scan_if #(parameter int NUM_DIGITS = 6);

  logic [4*NUM_DIGITS-1:0] count_bcd;
  logic                    snap_req;
  logic                    freeze;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    snap_ack;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;

  modport master (
    output count_bcd, snap_req, freeze, lz_blank, dp_mask,
    input  snap_ack, seg, dp, digit_en
  );

  modport slave (
    input  count_bcd, snap_req, freeze, lz_blank, dp_mask,
    output snap_ack, seg, dp, digit_en
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// One-digit BCD to active-high 7-segment decoder.
module bcd_to_7seg
  import rt_display_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[bcd_i];

endmodule

// File: rtl/rt_count_display_scan.sv
// Snapshots the BCD counter chain and scans it onto a multiplexed 7-seg display,
// with one dead cycle between digits to suppress ghosting.
module rt_count_display_scan
  import rt_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  rt_count_display_scan_if.slave bus
);

  localparam int DIVW = $clog2(REFRESH_DIV);
  localparam int IDXW = $clog2(NUM_DIGITS);

  scan_state_t                   state_q, state_d;
  logic [DIVW-1:0]               div_q, div_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0]         snap_q;
  logic                          snap_ack_q;
  logic [6:0]                    seg_q, seg_d;
  logic                          dp_q, dp_d;
  logic [NUM_DIGITS-1:0]         dig_q, dig_d;

  logic [NUM_DIGITS-1:0][6:0]    dec;
  logic [NUM_DIGITS-1:0]         lz;
  logic [NUM_DIGITS-1:0]         dig_a;
  logic [6:0]                    seg_a;
  logic                          dp_a;
  logic                          take;

  assign take = bus.snap_req & ~bus.freeze;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_to_7seg u_dec (.bcd_i(snap_q[g]), .seg_o(dec[g]));
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIVW'(REFRESH_DIV - 1)) begin
          state_d = BLANK;
          div_d   = '0;
          idx_d   = (idx_q == IDXW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      BLANK: begin
        state_d = SCAN;
        div_d   = '0;
      end
      default: state_d = SCAN;
    endcase
  end

  // lz[i]: digits i..top of the snapshot are all zero (digit 0 never blanks)
  always_comb begin
    logic all_zero;
    lz = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      all_zero = 1'b1;
      for (int j = i; j < NUM_DIGITS; j++)
        if (snap_q[j] != 4'd0) all_zero = 1'b0;
      lz[i] = all_zero;
    end
  end

  always_comb begin
    dig_a = '0;
    seg_a = SEG_OFF;
    dp_a  = 1'b0;
    if (state_q == SCAN) begin
      dig_a[idx_q] = 1'b1;
      seg_a        = (bus.lz_blank && lz[idx_q]) ? SEG_OFF : dec[idx_q];
      dp_a         = bus.dp_mask[idx_q];
    end
    seg_d = seg_a ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = dp_a ^ SEG_ACTIVE_LOW;
    dig_d = dig_a ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      div_q      <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      snap_ack_q <= 1'b0;
      seg_q      <= {7{SEG_ACTIVE_LOW}};
      dp_q       <= SEG_ACTIVE_LOW;
      dig_q      <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      if (take) snap_q <= bus.count_bcd;
      snap_ack_q <= take;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign bus.snap_ack = snap_ack_q;
  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.digit_en = dig_q;

endmodule

// File: tb/tb_rt_count_display_scan.sv
// Directed bench: 4 digits, 4-cycle slots; u1 has active-low segments, u2 active-high.
module tb_rt_count_display_scan;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rt_count_display_scan_if #(.NUM_DIGITS(4)) b1 ();
  rt_count_display_scan_if #(.NUM_DIGITS(4)) b2 ();

  assign b2.count_bcd = b1.count_bcd;
  assign b2.snap_req  = b1.snap_req;
  assign b2.freeze    = b1.freeze;
  assign b2.lz_blank  = b1.lz_blank;
  assign b2.dp_mask   = b1.dp_mask;

  rt_count_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  rt_count_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1))
    u2 (.clk(clk), .reset(reset), .bus(b2));

  int npass = 0;
  int ntot  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // seg/dp given in active-low form; u2 must show their complement
  task automatic chk_out(input string tag, input logic [3:0] dig, input logic [6:0] seg, input logic dp);
    logic [6:0] seg_n;
    logic       dp_n;
    seg_n = ~seg;
    dp_n  = ~dp;
    chk({tag, " dig"},  b1.digit_en, dig);
    chk({tag, " seg"},  b1.seg,      seg);
    chk({tag, " dp"},   b1.dp,       dp);
    chk({tag, " dig2"}, b2.digit_en, dig);
    chk({tag, " seg2"}, b2.seg,      seg_n);
    chk({tag, " dp2"},  b2.dp,       dp_n);
  endtask

  // One full frame from the first cycle of digit 0; optional snapshot in the last blank.
  task automatic frame(input int fr, input logic [3:0][6:0] es, input logic [3:0] edp,
                       input bit do_snap, input logic [15:0] sval, input logic exp_ack);
    logic [3:0] dig;
    for (int d = 0; d < 4; d++) begin
      dig = 4'b0001 << d;
      dig = ~dig;
      for (int c = 0; c < 4; c++) begin
        step();
        chk_out($sformatf("f%0d d%0d c%0d", fr, d, c), dig, es[d], edp[d]);
        if (d == 0 && c == 0) chk($sformatf("f%0d ack_lo", fr), b1.snap_ack, 1'b0);
      end
      if (do_snap && d == 3) begin
        b1.snap_req  = 1'b1;
        b1.count_bcd = sval;
      end
      step();
      chk_out($sformatf("f%0d d%0d blank", fr, d), 4'hF, 7'h7F, 1'b1);
      if (do_snap && d == 3) begin
        chk($sformatf("f%0d ack", fr), b1.snap_ack, exp_ack);
        chk($sformatf("f%0d ack2", fr), b2.snap_ack, exp_ack);
        b1.snap_req = 1'b0;
      end
    end
  endtask

  initial begin
    b1.count_bcd = '0;
    b1.snap_req  = 1'b0;
    b1.freeze    = 1'b0;
    b1.lz_blank  = 1'b0;
    b1.dp_mask   = '0;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("rst%0d", i), 4'hF, 7'h7F, 1'b1);
      chk($sformatf("rst%0d ack", i), b1.snap_ack, 1'b0);
    end
    reset = 1'b0;

    frame(1, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b1, 16'h1234, 1'b1);
    frame(2, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 1'b1, 16'h0070, 1'b1);

    b1.lz_blank = 1'b1;
    b1.dp_mask  = 4'b1000;
    frame(3, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0111, 1'b1, 16'h0005, 1'b1);

    b1.lz_blank = 1'b0;
    b1.dp_mask  = 4'b0000;
    b1.freeze   = 1'b1;
    frame(4, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 1'b1, 16'h9999, 1'b0);
    b1.freeze   = 1'b0;
    frame(5, {7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, 1'b1, 16'h9999, 1'b1);
    frame(6, {7'h10, 7'h10, 7'h10, 7'h10}, 4'hF, 1'b1, 16'h00A3, 1'b1);
    frame(7, {7'h40, 7'h40, 7'h7F, 7'h30}, 4'hF, 1'b0, 16'h0000, 1'b0);

    // walk to the third cycle of digit 2's slot, then reset on that edge
    for (int i = 0; i < 12; i++) step();
    chk_out("pre_rst", 4'b1011, 7'h40, 1'b1);
    reset = 1'b1;
    step();
    chk_out("mid_rst", 4'hF, 7'h7F, 1'b1);
    chk("mid_rst ack", b1.snap_ack, 1'b0);
    reset = 1'b0;
    frame(8, {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 1'b0, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
